imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 152 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator: decodes the opcode, builds the XLEN-wide immediate
// and branch target, and queues the results in a two-entry output skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  output logic [1:0]      count
);

  localparam logic [5:0] T_J = 6'b000001;
  localparam logic [5:0] T_U = 6'b000010;
  localparam logic [5:0] T_B = 6'b000100;
  localparam logic [5:0] T_S = 6'b001000;
  localparam logic [5:0] T_I = 6'b010000;
  localparam logic [5:0] T_Z = 6'b100000;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [5:0]      typ;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic [5:0]  d_type;
  logic        d_illegal;
  entry_t      d_entry;

  entry_t mem [DEPTH];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   push;
  logic   pop;
  entry_t head;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    imm32     = 32'h0;
    d_type    = 6'b0;
    d_illegal = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111: begin
        d_type = T_U;
        imm32  = {in_instr[31:12], 12'h000};
      end
      7'b1101111: begin
        d_type = T_J;
        imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
      end
      7'b1100011: begin
        d_type = T_B;
        imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
      end
      7'b0100011: begin
        d_type = T_S;
        imm32  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        d_type = T_I;
        imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0110011: ;
      7'b1110011: begin
        // CSR immediate forms carry a 5-bit unsigned uimm in the rs1 field
        if (funct3[2] && (funct3 != 3'b000)) begin
          d_type = T_Z;
          imm32  = {27'b0, in_instr[19:15]};
        end else begin
          d_type = T_I;
          imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Z immediates have bit 31 clear, so one sign-extension serves every format
  always_comb begin
    d_entry         = '0;
    d_entry.imm     = XLEN'($signed(imm32));
    d_entry.typ     = d_type;
    d_entry.pc      = in_pc;
    d_entry.target  = in_pc + XLEN'($signed(imm32));
    d_entry.illegal = d_illegal;
  end

  assign in_ready  = (count < 2'(DEPTH)) && !rst;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the buffer entries are reset too, so no stale partial entry survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= d_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // Data outputs read as zero whenever no entry is presented
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_imm     = head.imm;
  assign out_type    = head.typ;
  assign out_pc      = head.pc;
  assign out_target  = head.target;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_imm_gen_pipe;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [5:0]      out_type;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;
  logic [1:0]      count;

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_type   (out_type),
    .out_target (out_target),
    .out_pc     (out_pc),
    .out_illegal(out_illegal),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [5:0]  typ;
    logic [31:0] pc;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

  exp_t mq[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sext(input longint v, input int n);
    longint half;
    half = longint'(1) << (n - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  // Reference decode written from the immediate formulas with shifts and masks
  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    exp_t   e;
    longint w;
    longint v;
    int     f3;
    e  = '0;
    w  = longint'(instr);
    v  = 0;
    f3 = int'((w >> 12) & 7);
    case (int'(w & 'h7f))
      'h37, 'h17: begin e.typ = 6'b000010; v = sext(w & 'hFFFFF000, 32); end
      'h6f: begin
        e.typ = 6'b000001;
        v = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                 (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
      end
      'h63: begin
        e.typ = 6'b000100;
        v = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                 (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
      end
      'h23: begin e.typ = 6'b001000; v = sext((((w >> 25) & 127) << 5) | ((w >> 7) & 31), 12); end
      'h67, 'h03, 'h13: begin e.typ = 6'b010000; v = sext(w >> 20, 12); end
      'h33: v = 0;
      'h73: begin
        if (f3 >= 4) begin e.typ = 6'b100000; v = (w >> 15) & 31; end
        else begin e.typ = 6'b010000; v = sext(w >> 20, 12); end
      end
      default: e.illegal = 1'b1;
    endcase
    e.imm    = v[31:0];
    e.pc     = pc;
    e.target = pc + e.imm;
    return e;
  endfunction

  task automatic compare_model();
    exp_t e;
    e = '0;
    if (mq.size() != 0) e = mq[0];
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("count", 64'(count), 64'(mq.size()));
    check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    check("out_imm", 64'(out_imm), 64'(e.imm));
    check("out_type", 64'(out_type), 64'(e.typ));
    check("out_target", 64'(out_target), 64'(e.target));
    check("out_pc", 64'(out_pc), 64'(e.pc));
    check("out_illegal", 64'(out_illegal), 64'(e.illegal));
  endtask

  // One clock cycle: called just after a rising edge, returns just after the next one
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic m_push;
    logic m_pop;
    exp_t tmp;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    compare_model();
    m_push = v && (mq.size() < 2);
    m_pop  = (mq.size() != 0) && ordy;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (m_pop) tmp = mq.pop_front();
      if (m_push) mq.push_back(ref_decode(instr, pc));
    end
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [5:0] typ,
                          input logic [31:0] target, input logic ill);
    step(1'b1, instr, pc, 1'b0, 1'b0);
    check({tag, "_imm"}, 64'(out_imm), 64'(imm));
    check({tag, "_type"}, 64'(out_type), 64'(typ));
    check({tag, "_target"}, 64'(out_target), 64'(target));
    check({tag, "_illegal"}, 64'(out_illegal), 64'(ill));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h63, 7'h23, 7'h67, 7'h03, 7'h13, 7'h33, 7'h73};

  initial begin
    logic [31:0] r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    directed("i", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 6'b010000, 32'h000000FF, 1'b0);
    directed("j", 32'h0040006F, 32'h100, 32'h00000004, 6'b000001, 32'h00000104, 1'b0);
    directed("b", 32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 6'b000100, 32'h000000FC, 1'b0);
    directed("u", 32'h123450B7, 32'h0,   32'h12345000, 6'b000010, 32'h12345000, 1'b0);
    directed("z", 32'h300FD073, 32'h0,   32'h0000001F, 6'b100000, 32'h0000001F, 1'b0);
    directed("ill", 32'h00000000, 32'h200, 32'h0,      6'b000000, 32'h00000200, 1'b1);

    // Backpressure: three offered, two accepted, all drain in order
    step(1'b1, 32'h00100093, 32'hA00, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 32'hB00, 1'b0, 1'b0);
    check("bp_count", 64'(count), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h00300093, 32'hC00, 1'b0, 1'b0);
    check("bp_held_count", 64'(count), 64'd2);
    check("bp_head_a", 64'(out_pc), 64'hA00);
    step(1'b1, 32'h00300093, 32'hC00, 1'b1, 1'b0);
    check("bp_head_b", 64'(out_pc), 64'hB00);
    step(1'b1, 32'h00300093, 32'hC00, 1'b1, 1'b0);
    check("bp_head_c", 64'(out_pc), 64'hC00);
    check("bp_count_c", 64'(count), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush overrides the push offered in the same cycle
    step(1'b1, 32'h00400023, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00500023, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00600023, 32'h308, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_imm", 64'(out_imm), 64'd0);

    // Asynchronous reset between edges with a full buffer
    step(1'b1, 32'h00700037, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00800037, 32'h404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    check("arst_pc", 64'(out_pc), 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 9)];
      step(1'($urandom_range(0, 3) != 0), r, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
